// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues byte/half/word accesses over a req/ack RAM port,
// stalls the pipeline until completion, and flags misaligned accesses and RAM timeouts.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_memRead,
  input  logic        ex_memWrite,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_ALUResult,
  input  logic [31:0] ex_writeData,
  output logic        stall,
  output logic [31:0] mem_readData,
  output logic        misaligned,
  output logic        bus_err,
  output logic        ram_req,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] cnt;
  logic [2:0]    ldFunct3;
  logic [1:0]    ldOff;

  logic        isStore, access, f3Valid, aligned, legal, timeoutHit;
  logic [3:0]  wstrbNext;
  logic [31:0] wdataNext, laneData, loadExt;

  assign isStore    = ex_memWrite;
  assign access     = ex_memRead | ex_memWrite;
  assign timeoutHit = (cnt == CNT_LAST);

  // Stores only accept B/H/W; loads additionally accept the unsigned BU/HU forms.
  always_comb begin
    f3Valid = 1'b0;
    aligned = 1'b0;
    case (ex_funct3)
      3'b000:  begin f3Valid = 1'b1;     aligned = 1'b1; end
      3'b001:  begin f3Valid = 1'b1;     aligned = ~ex_ALUResult[0]; end
      3'b010:  begin f3Valid = 1'b1;     aligned = (ex_ALUResult[1:0] == 2'b00); end
      3'b100:  begin f3Valid = ~isStore; aligned = 1'b1; end
      3'b101:  begin f3Valid = ~isStore; aligned = ~ex_ALUResult[0]; end
      default: begin f3Valid = 1'b0;     aligned = 1'b0; end
    endcase
  end

  assign legal = access & f3Valid & aligned;

  always_comb begin
    wstrbNext = 4'b1111;
    wdataNext = ex_writeData;
    case (ex_funct3[1:0])
      2'b00: begin
        wstrbNext = 4'b0001 << ex_ALUResult[1:0];
        wdataNext = {4{ex_writeData[7:0]}};
      end
      2'b01: begin
        wstrbNext = ex_ALUResult[1] ? 4'b1100 : 4'b0011;
        wdataNext = {2{ex_writeData[15:0]}};
      end
      default: begin
        wstrbNext = 4'b1111;
        wdataNext = ex_writeData;
      end
    endcase
  end

  assign laneData = ram_rdata >> {ldOff, 3'b000};

  always_comb begin
    loadExt = ram_rdata;
    case (ldFunct3)
      3'b000:  loadExt = {{24{laneData[7]}}, laneData[7:0]};
      3'b100:  loadExt = {24'h0, laneData[7:0]};
      3'b001:  loadExt = {{16{laneData[15]}}, laneData[15:0]};
      3'b101:  loadExt = {16'h0, laneData[15:0]};
      default: loadExt = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // stall and misaligned are combinational so the pipeline reacts in the same cycle.
  always_comb begin
    stateNext  = state;
    stall      = 1'b0;
    misaligned = 1'b0;
    case (state)
      IDLE: begin
        if (legal) begin
          stall     = 1'b1;
          stateNext = WAIT;
        end else if (access) begin
          misaligned = 1'b1;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (ram_ack || timeoutHit) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (!rst) begin
      stall      = 1'b0;
      misaligned = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      ram_req      <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_wstrb    <= '0;
      mem_readData <= '0;
      bus_err      <= 1'b0;
      ldFunct3     <= '0;
      ldOff        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (legal) begin
            cnt       <= '0;
            ram_req   <= 1'b1;
            ram_we    <= isStore;
            ram_addr  <= {ex_ALUResult[31:2], 2'b00};
            ram_wstrb <= isStore ? wstrbNext : 4'b0000;
            ram_wdata <= isStore ? wdataNext : 32'h0;
            ldFunct3  <= ex_funct3;
            ldOff     <= ex_ALUResult[1:0];
          end else if (access) begin
            mem_readData <= '0;
          end
        end
        WAIT: begin
          if (ram_ack) begin
            ram_req <= 1'b0;
            if (!ram_we) mem_readData <= loadExt;
          end else if (timeoutHit) begin
            ram_req      <= 1'b0;
            mem_readData <= '0;
            bus_err      <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    bus_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench for mem_access_unit against an arithmetic reference model
// of load/store lane selection, alignment rules, stall length and timeout behaviour.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_memRead, ex_memWrite;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_ALUResult, ex_writeData;
  logic        stall, misaligned, bus_err;
  logic [31:0] mem_readData;
  logic        ram_req, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [3:0]  ram_wstrb;
  logic [31:0] ram_rdata;
  logic        ram_ack;

  int checks = 0;
  int errors = 0;
  logic [31:0] expRead = 32'h0;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_funct3(ex_funct3),
    .ex_ALUResult(ex_ALUResult), .ex_writeData(ex_writeData),
    .stall(stall), .mem_readData(mem_readData), .misaligned(misaligned), .bus_err(bus_err),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int accessSize(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic isLegal(input logic rd, input logic wr, input logic [2:0] f3,
                                   input logic [31:0] addr);
    logic okF3;
    if (!rd && !wr) return 1'b0;
    if (wr) okF3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    else    okF3 = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    return okF3 && ((addr % accessSize(f3)) == 0);
  endfunction

  function automatic logic [3:0] modelStrb(input logic [2:0] f3, input logic [31:0] addr);
    int s;
    s = accessSize(f3);
    return 4'(((1 << s) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] d);
    int s;
    s = accessSize(f3);
    if (s == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (s == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    logic [31:0] sh, v;
    int s;
    s  = accessSize(f3);
    sh = rdata >> (8 * (addr % 4));
    if (s == 4) return rdata;
    if (s == 1) begin
      v = sh & 32'hFF;
      if (!f3[2] && v >= 32'h80) v = v - 32'h100;
    end else begin
      v = sh & 32'hFFFF;
      if (!f3[2] && v >= 32'h8000) v = v - 32'h1_0000;
    end
    return v;
  endfunction

  task automatic clearInputs();
    ex_memRead   = 1'b0;
    ex_memWrite  = 1'b0;
    ex_funct3    = 3'd0;
    ex_ALUResult = 32'h0;
    ex_writeData = 32'h0;
    ram_ack      = 1'b0;
  endtask

  // Entered and left just after a rising edge; outputs are sampled on falling edges.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rdata, input int ackWait, input logic noAck);
    int  stallCycles, reqCycles, expStall, expReq;
    logic legal, finished;
    ex_memRead   = rd;
    ex_memWrite  = wr;
    ex_funct3    = f3;
    ex_ALUResult = addr;
    ex_writeData = wd;
    ram_ack      = 1'b0;
    legal        = isLegal(rd, wr, f3, addr);
    @(negedge clk);
    if (!legal) begin
      checkOutput("illegal.misaligned", 32'(misaligned), 32'(rd | wr));
      checkOutput("illegal.stall", 32'(stall), 32'h0);
      @(posedge clk); #1;
      if (rd || wr) expRead = 32'h0;
      checkOutput("illegal.readData", mem_readData, expRead);
      checkOutput("illegal.ramReq", 32'(ram_req), 32'h0);
      clearInputs();
      return;
    end
    checkOutput("idle.stall", 32'(stall), 32'h1);
    checkOutput("idle.misaligned", 32'(misaligned), 32'h0);
    @(posedge clk); #1;
    checkOutput("wait.ramReq", 32'(ram_req), 32'h1);
    checkOutput("wait.ramWe", 32'(ram_we), 32'(wr));
    checkOutput("wait.ramAddr", ram_addr, addr & 32'hFFFF_FFFC);
    checkOutput("wait.ramWstrb", 32'(ram_wstrb), wr ? 32'(modelStrb(f3, addr)) : 32'h0);
    if (wr) checkOutput("wait.ramWdata", ram_wdata, modelWdata(f3, wd));
    stallCycles = 1;
    reqCycles   = 0;
    finished    = 1'b0;
    for (int i = 0; i < TIMEOUT + 8; i++) begin
      if (!noAck && i == ackWait) begin
        ram_ack   = 1'b1;
        ram_rdata = rdata;
      end
      @(negedge clk);
      if (!stall) begin
        finished = 1'b1;
        break;
      end
      stallCycles++;
      if (ram_req) reqCycles++;
      @(posedge clk); #1;
      ram_ack   = 1'b0;
      ram_rdata = $urandom;
    end
    checkOutput("done.reached", 32'(finished), 32'h1);
    expStall = noAck ? TIMEOUT + 1 : ackWait + 2;
    expReq   = noAck ? TIMEOUT : ackWait + 1;
    checkOutput("done.stallCycles", 32'(stallCycles), 32'(expStall));
    checkOutput("done.reqCycles", 32'(reqCycles), 32'(expReq));
    checkOutput("done.ramReq", 32'(ram_req), 32'h0);
    checkOutput("done.busErr", 32'(bus_err), 32'(noAck));
    if (noAck)   expRead = 32'h0;
    else if (rd && !wr) expRead = modelLoad(f3, addr, rdata);
    checkOutput("done.readData", mem_readData, expRead);
    @(posedge clk); #1;
    clearInputs();
    checkOutput("after.busErr", 32'(bus_err), 32'h0);
  endtask

  // Idle cycle with a stray ack, which must not start or complete anything.
  task automatic idleCycle();
    clearInputs();
    ram_ack   = 1'($urandom_range(0, 1));
    ram_rdata = $urandom;
    @(negedge clk);
    checkOutput("idleCycle.stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    checkOutput("idleCycle.ramReq", 32'(ram_req), 32'h0);
    checkOutput("idleCycle.readData", mem_readData, expRead);
    ram_ack = 1'b0;
  endtask

  initial begin
    logic rd, wr, noAck;
    logic [2:0]  f3;
    logic [31:0] addr;
    clearInputs();
    ram_rdata = 32'h0;
    rst = 1'b1;
    #2 rst = 1'b0;
    ex_memRead = 1'b1;
    ex_funct3  = 3'd2;
    #1;
    checkOutput("reset.stall", 32'(stall), 32'h0);
    ex_funct3 = 3'd3;
    #1;
    checkOutput("reset.misaligned", 32'(misaligned), 32'h0);
    checkOutput("reset.ramReq", 32'(ram_req), 32'h0);
    checkOutput("reset.outs", {ram_wdata ^ ram_addr ^ mem_readData}, 32'h0);
    checkOutput("reset.flags", {26'h0, ram_we, bus_err, ram_wstrb}, 32'h0);
    clearInputs();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    applyStimulus(1'b0, 1'b1, 3'd2, 32'h8, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd0, 32'h5, 32'h0, 32'h0000_8000, 2, 1'b0);
    checkOutput("lb.value", mem_readData, 32'hFFFF_FF80);
    applyStimulus(1'b1, 1'b0, 3'd4, 32'h5, 32'h0, 32'h0000_8000, 0, 1'b0);
    checkOutput("lbu.value", mem_readData, 32'h0000_0080);
    applyStimulus(1'b0, 1'b1, 3'd1, 32'h6, 32'h1234, 32'h0, 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd1, 32'h3, 32'h0, 32'h0, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 3'd2, 32'h40, 32'h0, 32'h0, 0, 1'b1);
    applyStimulus(1'b1, 1'b1, 3'd2, 32'hC, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 3'd3, 32'hC, 32'h0, 32'h0, 0, 1'b0);
    idleCycle();

    // Reset asserted during the second WAIT cycle of a load.
    ex_memRead   = 1'b1;
    ex_funct3    = 3'd2;
    ex_ALUResult = 32'h10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("midReset.ramReq", 32'(ram_req), 32'h0);
    checkOutput("midReset.stall", 32'(stall), 32'h0);
    clearInputs();
    expRead = 32'h0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    idleCycle();
    applyStimulus(1'b1, 1'b0, 3'd5, 32'h12, 32'h0, 32'h8765_4321, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      rd    = 1'($urandom_range(0, 1));
      wr    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = $urandom;
      noAck = ($urandom_range(0, 9) == 0);
      applyStimulus(rd, wr, f3, addr, $urandom, $urandom, $urandom_range(0, 4), noAck);
      if ($urandom_range(0, 2) == 0) idleCycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
